// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter that shares one FIFO write port among
// num_req valid/ready producers. Each grant is held for bursts of up to burst_max words.
`default_nettype none

module fifo_write_arbiter #(
  parameter int width     = 8,
  parameter int num_req   = 4,
  parameter int burst_max = 4,
  parameter int id_width  = $clog2(num_req),
  parameter int cnt_width = $clog2(burst_max + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [num_req-1:0]         req_valid,
  input  logic [num_req*width-1:0]   req_data,
  output logic [num_req-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_write_en,
  output logic [width-1:0]           fifo_din,
  output logic [id_width-1:0]        grant_id
);

  localparam int id_w1 = id_width + 1;
  localparam logic [cnt_width-1:0] burst_last = cnt_width'(burst_max);
  localparam logic [id_width-1:0]  last_id    = id_width'(num_req - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t                state, next_state;
  logic [id_width-1:0]   owner, next_owner;
  logic [id_width-1:0]   rr_ptr, next_rr_ptr;
  logic [cnt_width-1:0]  burst_cnt, next_burst_cnt;

  logic                  cand_found;
  logic [id_width-1:0]   cand;
  logic [id_w1-1:0]      scan_idx;
  logic                  xfer;
  logic [id_width-1:0]   xfer_id;

  function automatic logic [id_width-1:0] wrap_inc(input logic [id_width-1:0] x);
    return (x == last_id) ? '0 : x + 1'b1;
  endfunction

  // Scan rr_ptr, rr_ptr+1, ... modulo num_req; the index never reaches num_req.
  always_comb begin
    cand_found = 1'b0;
    cand       = '0;
    scan_idx   = '0;
    for (int k = 0; k < num_req; k++) begin
      scan_idx = {1'b0, rr_ptr} + id_w1'(k);
      if (scan_idx >= id_w1'(num_req))
        scan_idx = scan_idx - id_w1'(num_req);
      if (!cand_found && req_valid[scan_idx[id_width-1:0]]) begin
        cand_found = 1'b1;
        cand       = scan_idx[id_width-1:0];
      end
    end
  end

  always_comb begin
    next_state     = state;
    next_owner     = owner;
    next_rr_ptr    = rr_ptr;
    next_burst_cnt = burst_cnt;
    xfer           = 1'b0;
    xfer_id        = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (cand_found && !fifo_full) begin
            xfer    = 1'b1;
            xfer_id = cand;
            if (burst_max > 1) begin
              next_state     = LOCK;
              next_owner     = cand;
              next_burst_cnt = cnt_width'(1);
            end else begin
              next_rr_ptr = wrap_inc(cand);
            end
          end
        end
        LOCK: begin
          if (req_valid[owner]) begin
            if (!fifo_full) begin
              xfer    = 1'b1;
              xfer_id = owner;
              if (burst_cnt + 1'b1 == burst_last) begin
                next_state     = IDLE;
                next_rr_ptr    = wrap_inc(owner);
                next_burst_cnt = '0;
              end else begin
                next_burst_cnt = burst_cnt + 1'b1;
              end
            end
          end else begin
            // Owner dropped valid: give up the lock, costing one idle cycle.
            next_state     = IDLE;
            next_rr_ptr    = wrap_inc(owner);
            next_burst_cnt = '0;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= next_state;
      owner     <= next_owner;
      rr_ptr    <= next_rr_ptr;
      burst_cnt <= next_burst_cnt;
    end
  end

  always_comb begin
    req_ready     = '0;
    fifo_write_en = xfer;
    fifo_din      = '0;
    grant_id      = '0;
    if (xfer) begin
      req_ready[xfer_id] = 1'b1;
      fifo_din           = req_data[xfer_id*width +: width];
      grant_id           = xfer_id;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed vectors for the default arbiter plus a
// burst_max=1 instance feeding a 16-deep FIFO model.
`default_nettype none

module tb_fifo_write_arbiter;
  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_data;
  logic           fifo_full, fifo_write_en;
  logic [W-1:0]   fifo_din;
  logic [1:0]     grant_id;

  logic [N-1:0]   v2, rdy2;
  logic [N*W-1:0] d2;
  logic           full2, we2;
  logic [W-1:0]   din2;
  logic [1:0]     gid2;

  fifo_write_arbiter #(.width(W), .num_req(N), .burst_max(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_write_en(fifo_write_en),
    .fifo_din(fifo_din), .grant_id(grant_id)
  );

  fifo_write_arbiter #(.width(W), .num_req(N), .burst_max(1)) dut_b1 (
    .clk(clk), .reset(reset), .req_valid(v2), .req_data(d2),
    .req_ready(rdy2), .fifo_full(full2), .fifo_write_en(we2),
    .fifo_din(din2), .grant_id(gid2)
  );

  // 16-deep FIFO model with combinational full flag.
  logic [W-1:0] mem [16];
  int           count;
  assign full2 = (count == 16);
  always @(posedge clk or posedge reset) begin
    if (reset) count <= 0;
    else if (we2 && !full2) begin
      mem[count] <= din2;
      count      <= count + 1;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '0; v2 = '0; fifo_full = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 4'b0100; fifo_full = 1'b0; v2 = '0;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    d2 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    #1;
    check_val("rst_ready", 32'(req_ready), 32'h0);
    check_val("rst_we", 32'(fifo_write_en), 32'h0);
    check_val("rst_din", 32'(fifo_din), 32'h0);
    check_val("rst_gid", 32'(grant_id), 32'h0);
    @(negedge clk); reset = 1'b0; req_valid = '0;

    // 1: single producer 2, five writes with no bubble at the burst boundary
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid = 4'b0100; req_data[16 +: 8] = 8'h11 + 8'(k);
      #1;
      check_val("t1_we", 32'(fifo_write_en), 32'h1);
      check_val("t1_gid", 32'(grant_id), 32'h2);
      check_val("t1_din", 32'(fifo_din), 32'h11 + k);
    end
    @(negedge clk); req_valid = '0; #1;
    check_val("t1_idle_we", 32'(fifo_write_en), 32'h0);
    check_val("t1_idle_gid", 32'(grant_id), 32'h0);

    // 2: four-way rotation
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    do_reset();
    for (int k = 0; k < 17; k++) begin
      @(negedge clk); req_valid = 4'b1111; #1;
      check_val("t2_gid", 32'(grant_id), 32'((k / 4) % 4));
      check_val("t2_din", 32'(fifo_din), 32'h11 * ((k / 4) % 4 + 1));
      check_val("t2_we", 32'(fifo_write_en), 32'h1);
    end

    // 3: stall on full inside producer 1's burst
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); req_valid = 4'b0110; #1;
      check_val("t3_pre_ready", 32'(req_ready), 32'b0010);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); fifo_full = 1'b1; #1;
      check_val("t3_stall_ready", 32'(req_ready), 32'h0);
      check_val("t3_stall_we", 32'(fifo_write_en), 32'h0);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); fifo_full = 1'b0; #1;
      check_val("t3_post_ready", 32'(req_ready), 32'b0010);
      check_val("t3_post_gid", 32'(grant_id), 32'h1);
    end
    @(negedge clk); #1;
    check_val("t3_next_gid", 32'(grant_id), 32'h2);
    check_val("t3_next_ready", 32'(req_ready), 32'b0100);

    // 4: owner release costs one idle cycle
    do_reset();
    @(negedge clk); req_valid = 4'b1001; #1;
    check_val("t4_first_gid", 32'(grant_id), 32'h0);
    check_val("t4_first_we", 32'(fifo_write_en), 32'h1);
    @(negedge clk); req_valid = 4'b1000; #1;
    check_val("t4_bubble_we", 32'(fifo_write_en), 32'h0);
    @(negedge clk); #1;
    check_val("t4_next_gid", 32'(grant_id), 32'h3);
    check_val("t4_next_we", 32'(fifo_write_en), 32'h1);

    // 5: reset during producer 2's third word
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); req_valid = 4'b0100; #1;
      check_val("t5_pre_gid", 32'(grant_id), 32'h2);
    end
    @(negedge clk); reset = 1'b1; #1;
    check_val("t5_rst_we", 32'(fifo_write_en), 32'h0);
    check_val("t5_rst_ready", 32'(req_ready), 32'h0);
    check_val("t5_rst_din", 32'(fifo_din), 32'h0);
    @(negedge clk); reset = 1'b0; req_valid = 4'b1001; #1;
    check_val("t5_after_gid", 32'(grant_id), 32'h0);
    check_val("t5_after_we", 32'(fifo_write_en), 32'h1);

    // 6: burst_max=1 rotation until the FIFO fills
    do_reset();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); v2 = 4'b1111; #1;
      check_val("t6_gid", 32'(gid2), 32'(k % 4));
      check_val("t6_din", 32'(din2), 32'hA0 + (k % 4));
      check_val("t6_we", 32'(we2), 32'h1);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      check_val("t6_full", 32'(full2), 32'h1);
      check_val("t6_full_we", 32'(we2), 32'h0);
      check_val("t6_full_ready", 32'(rdy2), 32'h0);
    end
    for (int k = 0; k < 16; k++)
      check_val("t6_mem", 32'(mem[k]), 32'hA0 + (k % 4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
